// File: rtl/nic8_mem_arbiter.sv
// nic8_mem_arbiter: shares the nic8 RAM between the CPU (priority) and a host port with a starvation guard.
// Optional NIC8_ARB_HALT_EN adds host_halt/cpu_halted so the host can freeze the CPU outright.
module nic8_mem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
`ifdef NIC8_ARB_HALT_EN
    input  logic              host_halt,
    output logic              cpu_halted,
`endif
    input  logic [DATA_W-1:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;
    state_t state;
    logic [3:0] starveCnt;
    logic halt, starved, hostGrant;
`ifdef NIC8_ARB_HALT_EN
    assign halt = host_halt;
`else
    assign halt = 1'b0;
`endif
    assign starved   = starveCnt == 4'(STARVE_MAX);
    // ACK ignores host_req so a request still held while its ack is visible is not serviced twice
    assign hostGrant = rst_n && state != ACK && host_req && (!cpu_req || starved || halt);
    assign cpu_stall = rst_n && ((hostGrant && cpu_req) || halt);
    assign ram_addr  = hostGrant ? host_addr : cpu_addr;
    assign ram_wdata = hostGrant ? host_wdata : cpu_wdata;
    assign ram_we    = hostGrant ? host_we : rst_n && cpu_req && cpu_we && !cpu_stall;
    assign cpu_rdata = ram_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            starveCnt  <= 4'd0;
            host_ack   <= 1'b0;
            host_rdata <= '0;
        end else begin
            state     <= hostGrant ? ACK : (state != ACK && host_req) ? WAIT : IDLE;
            host_ack  <= hostGrant;
            starveCnt <= (hostGrant || !host_req) ? 4'd0 : starved ? starveCnt : starveCnt + 4'd1;
            if (hostGrant && !host_we)
                host_rdata <= ram_rdata;
        end
    end

`ifdef NIC8_ARB_HALT_EN
    always_ff @(posedge clk)
        cpu_halted <= rst_n && host_halt;
`endif
endmodule

// File: tb/tb_nic8_mem_arbiter.sv
// tb_nic8_mem_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_nic8_mem_arbiter;
    localparam int STARVE_MAX = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic cpu_req = 1'b0, cpu_we = 1'b0, host_req = 1'b0, host_we = 1'b0;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0, host_addr = '0, host_wdata = '0;
    logic [7:0] cpu_rdata, host_rdata, ram_addr, ram_wdata, ram_rdata;
    logic cpu_stall, host_ack, ram_we;
    logic [7:0] mem [256];
    logic [7:0] refMem [256];
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    nic8_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // RAM: asynchronous read, write lands at posedge
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        cpu_req = 1'b0; cpu_we = 1'b0; host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h33; cpu_wdata = 8'hEE;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h44; host_wdata = 8'h99;
        tick; tick;
        total++; if (host_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", host_ack); else passed++;
        total++; if (host_rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", host_rdata); else passed++;
        total++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we: got %b want 0", ram_we); else passed++;
        total++; if (cpu_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", cpu_stall); else passed++;
        rst_n = 1'b1; idle; tick;
    endtask

    task automatic test_cpu_only;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
        #1;
        total++; if (cpu_stall !== 1'b0) $display("FAIL cpu_wr_stall: got %b want 0", cpu_stall); else passed++;
        total++; if (ram_we !== 1'b1) $display("FAIL cpu_wr_we: got %b want 1", ram_we); else passed++;
        tick;
        total++; if (host_ack !== 1'b0) $display("FAIL cpu_wr_ack: got %b want 0", host_ack); else passed++;
        cpu_we = 1'b0;
        #1;
        total++; if (cpu_rdata !== 8'hA5) $display("FAIL cpu_rd_data: got %h want a5", cpu_rdata); else passed++;
        total++; if (cpu_stall !== 1'b0) $display("FAIL cpu_rd_stall: got %b want 0", cpu_stall); else passed++;
        tick;
        total++; if (host_ack !== 1'b0) $display("FAIL cpu_rd_ack: got %b want 0", host_ack); else passed++;
        idle;
    endtask

    task automatic test_host_idle;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h80; host_wdata = 8'h3C;
        #1;
        total++; if (ram_we !== 1'b1 || ram_addr !== 8'h80) $display("FAIL host_wr_mux: got we=%b addr=%h want we=1 addr=80", ram_we, ram_addr); else passed++;
        tick;
        total++; if (host_ack !== 1'b1) $display("FAIL host_wr_ack: got %b want 1", host_ack); else passed++;
        host_req = 1'b0;
        tick;
        total++; if (host_ack !== 1'b0) $display("FAIL host_wr_ack_drop: got %b want 0", host_ack); else passed++;
        host_req = 1'b1; host_we = 1'b0;
        tick;
        total++; if (host_ack !== 1'b1) $display("FAIL host_rd_ack: got %b want 1", host_ack); else passed++;
        total++; if (host_rdata !== 8'h3C) $display("FAIL host_rd_data: got %h want 3c", host_rdata); else passed++;
        host_req = 1'b0;
        tick;
    endtask

    task automatic test_starvation;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h11;
        tick;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
        // CPU reads 0x20 while the host waits, then tries to write 0x77 in the cycle the host is forced
        for (int k = 0; k <= STARVE_MAX; k++) begin
            logic expStall;
            expStall = (k == STARVE_MAX);
            cpu_we = expStall; cpu_wdata = 8'h77;
            #1;
            total++; if (cpu_stall !== expStall) $display("FAIL starve_stall_%0d: got %b want %b", k, cpu_stall, expStall); else passed++;
            tick;
        end
        total++; if (host_ack !== 1'b1) $display("FAIL starve_ack: got %b want 1", host_ack); else passed++;
        total++; if (host_rdata !== 8'h11) $display("FAIL starve_rdata: got %h want 11", host_rdata); else passed++;
        host_req = 1'b0;
        #1;
        total++; if (cpu_stall !== 1'b0) $display("FAIL starve_retry_stall: got %b want 0", cpu_stall); else passed++;
        total++; if (cpu_rdata !== 8'h11) $display("FAIL starve_blocked_write: got %h want 11", cpu_rdata); else passed++;
        tick;
        cpu_we = 1'b0;
        #1;
        total++; if (cpu_rdata !== 8'h77) $display("FAIL starve_retry_write: got %h want 77", cpu_rdata); else passed++;
        tick;
        idle;
    endtask

    task automatic test_held_req;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h80;
        for (int c = 1; c <= 5; c++) begin
            logic expAck;
            expAck = (c == 2 || c == 4);
            if (c == 5) host_req = 1'b0;
            #1;
            total++; if (host_ack !== expAck) $display("FAIL held_ack_c%0d: got %b want %b", c, host_ack, expAck); else passed++;
            tick;
        end
        total++; if (host_rdata !== 8'h3C) $display("FAIL held_rdata: got %h want 3c", host_rdata); else passed++;
    endtask

    task automatic test_reset_wait;
        int grantAt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        tick; tick;
        rst_n = 1'b0;
        #1;
        total++; if (cpu_stall !== 1'b0 || ram_we !== 1'b0) $display("FAIL rstwait_outputs: got stall=%b we=%b want 0 0", cpu_stall, ram_we); else passed++;
        tick;
        total++; if (host_ack !== 1'b0) $display("FAIL rstwait_no_ack: got %b want 0", host_ack); else passed++;
        rst_n = 1'b1;
        grantAt = -1;
        for (int k = 0; k < STARVE_MAX + 4 && grantAt < 0; k++) begin
            #1;
            if (cpu_stall) grantAt = k;
            tick;
        end
        total++; if (grantAt !== STARVE_MAX) $display("FAIL rstwait_grant_cycle: got %0d want %0d", grantAt, STARVE_MAX); else passed++;
        total++; if (host_ack !== 1'b1) $display("FAIL rstwait_ack: got %b want 1", host_ack); else passed++;
        total++; if (host_rdata !== 8'hA5) $display("FAIL rstwait_rdata: got %h want a5", host_rdata); else passed++;
        idle;
        tick;
    endtask

    task automatic test_random;
        bit hostActive = 1'b0, inAck = 1'b0, cpuHold = 1'b0, expGrant;
        int hostK = 0;
        logic [7:0] expRd = 8'h00;
        rst_n = 1'b0; idle; tick;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'(i); cpu_wdata = 8'($urandom);
            refMem[i] = cpu_wdata;
            tick;
        end
        for (int n = 0; n < 1500; n++) begin
            if (!cpuHold) begin
                cpu_req = ($urandom_range(0, 3) != 0); cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
            end
            if (!hostActive && !inAck && $urandom_range(0, 3) == 0) begin
                hostActive = 1'b1; hostK = 0; host_we = 1'($urandom_range(0, 1));
                host_addr = 8'($urandom_range(0, 15)); host_wdata = 8'($urandom);
            end
            host_req = hostActive;
            #1;
            // host is served on the first cycle the CPU is idle, or after waiting STARVE_MAX cycles
            expGrant = hostActive && (!cpu_req || hostK == STARVE_MAX);
            total++; if (cpu_stall !== (expGrant && cpu_req)) $display("FAIL rnd_stall_%0d: got %b want %b", n, cpu_stall, expGrant && cpu_req); else passed++;
            if (cpu_req && !cpu_we && !cpu_stall) begin
                total++; if (cpu_rdata !== refMem[cpu_addr]) $display("FAIL rnd_cpu_rdata_%0d: got %h want %h", n, cpu_rdata, refMem[cpu_addr]); else passed++;
            end
            if (expGrant) begin
                if (host_we) refMem[host_addr] = host_wdata;
                else expRd = refMem[host_addr];
                hostActive = 1'b0;
            end else begin
                if (hostActive) hostK++;
                if (cpu_req && cpu_we) refMem[cpu_addr] = cpu_wdata;
            end
            cpuHold = expGrant && cpu_req;
            tick;
            total++; if (host_ack !== expGrant) $display("FAIL rnd_ack_%0d: got %b want %b", n, host_ack, expGrant); else passed++;
            total++; if (host_rdata !== expRd) $display("FAIL rnd_host_rdata_%0d: got %h want %h", n, host_rdata, expRd); else passed++;
            inAck = expGrant;
        end
        host_req = 1'b0; cpu_we = 1'b0; cpu_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cpu_addr = 8'(i);
            #1;
            total++; if (cpu_rdata !== refMem[i]) $display("FAIL rnd_final_%0d: got %h want %h", i, cpu_rdata, refMem[i]); else passed++;
            tick;
        end
        idle;
    endtask

    initial begin
        test_reset;
        test_cpu_only;
        test_host_idle;
        test_starvation;
        test_held_req;
        test_reset_wait;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
